hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/hazard_ctl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - pipeline hazard controller: stall, flush, halt, stall watchdog (optional stats: HAZARD_STATS_EN)

`ifndef TRAP_STALL
`define TRAP_STALL 8'hFE
`endif

module hazard_ctl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int STALL_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_we,
    input  logic        mem_we,
    input  logic        wb_we,
    input  logic        br_redirect,
    input  logic [7:0]  exc_in,
    output logic        pc_hold,
    output logic        ex_bubble,
    output logic        id_squash,
    output logic        halted,
    output logic [7:0]  exc_out
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] L_FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);
    localparam logic [7:0] L_WD_LAST    = 8'(STALL_MAX - 1);

    state_t     r_state;
    state_t     w_state_n;
    logic [1:0] r_flush_cnt;
    logic [1:0] w_flush_cnt_n;
    logic [7:0] r_stall_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_wd_trip;
    logic w_exc_halt;
    logic w_halt_ev;

    // Source-register match against every in-flight writer; r0 never creates a dependency
    always_comb begin
        w_rs_hit = id_uses_rs && (id_rs != 5'd0) &&
                   ((ex_we && ex_rd == id_rs) || (mem_we && mem_rd == id_rs) ||
                    (wb_we && wb_rd == id_rs));
        w_rt_hit = id_uses_rt && (id_rt != 5'd0) &&
                   ((ex_we && ex_rd == id_rt) || (mem_we && mem_rd == id_rt) ||
                    (wb_we && wb_rd == id_rt));
        w_hazard = w_rs_hit || w_rt_hit;
    end

    // Mealy outputs; all forced low while rst is asserted
    always_comb begin
        pc_hold   = !rst && w_hazard && !br_redirect &&
                    (r_state == S_RUN || r_state == S_STALL);
        id_squash = !rst && (r_state == S_FLUSH || br_redirect);
        ex_bubble = pc_hold || id_squash;
        halted    = !rst && (r_state == S_HALT);
    end

    // Watchdog trips on the stall cycle that brings the count up to STALL_MAX
    always_comb begin
        w_wd_trip  = pc_hold && (r_stall_cnt == L_WD_LAST);
        w_exc_halt = (exc_in != 8'd0) && (exc_in != `TRAP_STALL);
        w_halt_ev  = w_exc_halt || w_wd_trip;
    end

    // Next-state and flush-counter logic; priority is halt, redirect, hazard
    always_comb begin
        w_state_n     = r_state;
        w_flush_cnt_n = r_flush_cnt;
        case (r_state)
            S_RUN, S_STALL: begin
                if (w_halt_ev) begin
                    w_state_n = S_HALT;
                end else if (br_redirect) begin
                    w_state_n     = S_FLUSH;
                    w_flush_cnt_n = L_FLUSH_LOAD;
                end else if (w_hazard) begin
                    w_state_n = S_STALL;
                end else begin
                    w_state_n = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_halt_ev) begin
                    w_state_n = S_HALT;
                end else if (br_redirect) begin
                    w_flush_cnt_n = L_FLUSH_LOAD;
                end else if (r_flush_cnt == 2'd0) begin
                    w_state_n = w_hazard ? S_STALL : S_RUN;
                end else begin
                    w_flush_cnt_n = r_flush_cnt - 2'd1;
                end
            end
            S_HALT: begin
                w_state_n = S_HALT;
            end
            default: begin
                w_state_n = S_RUN;
            end
        endcase
    end

    // State register with flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_n;
            r_flush_cnt <= w_flush_cnt_n;
        end
    end

    // Consecutive-stall counter and one-cycle watchdog exception code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 8'd0;
            exc_out     <= 8'd0;
        end else begin
            r_stall_cnt <= pc_hold ? r_stall_cnt + 8'd1 : 8'd0;
            exc_out     <= w_wd_trip ? `TRAP_STALL : 8'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    // Free-running stall/squash statistics, frozen once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_cycles <= 32'd0;
        end else if (r_state != S_HALT) begin
            stall_cycles <= stall_cycles + {31'd0, pc_hold};
            flush_cycles <= flush_cycles + {31'd0, id_squash};
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb/tb_hazard_ctl.sv - scoreboard bench for hazard_ctl

`ifndef TRAP_STALL
`define TRAP_STALL 8'hFE
`endif

module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, ex_we, mem_we, wb_we, br_redirect;
    logic [7:0]  exc_in;
    logic        pc_hold, ex_bubble, id_squash, halted;
    logic [7:0]  exc_out;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic       hold;
        logic       sq;
        logic       halt;
        logic [7:0] exc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctl #(.FLUSH_DEPTH(2), .STALL_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .br_redirect(br_redirect), .exc_in(exc_in),
        .pc_hold(pc_hold), .ex_bubble(ex_bubble), .id_squash(id_squash),
        .halted(halted), .exc_out(exc_out)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_we = 0; mem_we = 0; wb_we = 0;
        br_redirect = 0; exc_in = 0;
    endtask

    // Hazard on id_rs=3 from EX
    task automatic haz();
        ex_rd = 5'd3; ex_we = 1; id_rs = 5'd3; id_uses_rs = 1;
    endtask

    // Push expectation for the cycle being driven, then pop and compare mid-cycle
    task automatic step(input string tag, input logic h, input logic sq, input logic ht, input logic [7:0] ex);
        exp_t e;
        exp_t g;
        e.tag = tag; e.hold = h; e.sq = sq; e.halt = ht; e.exc = ex;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk({g.tag, ".pc_hold"},   {31'd0, pc_hold},   {31'd0, g.hold});
        chk({g.tag, ".ex_bubble"}, {31'd0, ex_bubble}, {31'd0, g.hold | g.sq});
        chk({g.tag, ".id_squash"}, {31'd0, id_squash}, {31'd0, g.sq});
        chk({g.tag, ".halted"},    {31'd0, halted},    {31'd0, g.halt});
        chk({g.tag, ".exc_out"},   {24'd0, exc_out},   {24'd0, g.exc});
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;

        // reset overrides hazard and redirect
        rst = 1; br_redirect = 1; haz(); step("rst0", 0, 0, 0, 8'd0);
        rst = 1; step("rst1", 0, 0, 0, 8'd0);
        step("idle0", 0, 0, 0, 8'd0);

        // load-use moving down the pipe
        ex_we = 1;  ex_rd = 5;  id_rs = 5; id_uses_rs = 1; step("lu_ex",  1, 0, 0, 8'd0);
        mem_we = 1; mem_rd = 5; id_rs = 5; id_uses_rs = 1; step("lu_mem", 1, 0, 0, 8'd0);
        wb_we = 1;  wb_rd = 5;  id_rs = 5; id_uses_rs = 1; step("lu_wb",  1, 0, 0, 8'd0);
        id_rs = 5; id_uses_rs = 1; step("lu_done", 0, 0, 0, 8'd0);

        // r0, use gating, write-enable gating, rt match
        ex_rd = 0; ex_we = 1; id_rt = 0; id_uses_rt = 1; step("r0", 0, 0, 0, 8'd0);
        ex_rd = 7; ex_we = 1; id_rs = 7; id_uses_rs = 0; step("nouse", 0, 0, 0, 8'd0);
        mem_rd = 9; mem_we = 0; id_rt = 9; id_uses_rt = 1; step("nowe", 0, 0, 0, 8'd0);
        wb_rd = 12; wb_we = 1; id_rt = 12; id_uses_rt = 1; step("rt_wb", 1, 0, 0, 8'd0);
        step("idle1", 0, 0, 0, 8'd0);

        // single redirect squashes three cycles
        br_redirect = 1; step("br_n", 0, 1, 0, 8'd0);
        step("br_n1", 0, 1, 0, 8'd0);
        step("br_n2", 0, 1, 0, 8'd0);
        step("br_n3", 0, 0, 0, 8'd0);

        // second redirect extends squash
        br_redirect = 1; step("bb_n",  0, 1, 0, 8'd0);
        br_redirect = 1; step("bb_n1", 0, 1, 0, 8'd0);
        step("bb_n2", 0, 1, 0, 8'd0);
        step("bb_n3", 0, 1, 0, 8'd0);
        step("bb_n4", 0, 0, 0, 8'd0);

        // redirect during stall, flush exits into stall
        haz(); step("rs_0", 1, 0, 0, 8'd0);
        haz(); br_redirect = 1; step("rs_1", 0, 1, 0, 8'd0);
        haz(); step("rs_2", 0, 1, 0, 8'd0);
        haz(); step("rs_3", 0, 1, 0, 8'd0);
        haz(); step("rs_4", 1, 0, 0, 8'd0);
        step("rs_5", 0, 0, 0, 8'd0);

        // stall counter clears between runs: 3+3 never trips
        for (int i = 0; i < 3; i++) begin haz(); step("sc_a", 1, 0, 0, 8'd0); end
        step("sc_gap", 0, 0, 0, 8'd0);
        for (int i = 0; i < 3; i++) begin haz(); step("sc_b", 1, 0, 0, 8'd0); end
        step("sc_end", 0, 0, 0, 8'd0);

        // exc_in equal to the watchdog code does not halt
        exc_in = `TRAP_STALL; step("trap_in", 0, 0, 0, 8'd0);
        step("trap_in1", 0, 0, 0, 8'd0);

        // halt beats redirect
        exc_in = 8'h02; br_redirect = 1; step("hb_0", 0, 1, 0, 8'd0);
        step("hb_1", 0, 0, 1, 8'd0);
        br_redirect = 1; step("hb_2", 0, 1, 1, 8'd0);
        step("hb_3", 0, 0, 1, 8'd0);
        rst = 1; step("hb_rst", 0, 0, 0, 8'd0);
        step("hb_idle", 0, 0, 0, 8'd0);

        // exception halt is absorbing until reset
        exc_in = 8'h01; step("ex_0", 0, 0, 0, 8'd0);
        step("ex_1", 0, 0, 1, 8'd0);
        haz(); step("ex_2", 0, 0, 1, 8'd0);
        rst = 1; br_redirect = 1; step("ex_rst", 0, 0, 0, 8'd0);
        step("ex_idle", 0, 0, 0, 8'd0);

        // watchdog with STALL_MAX=4
        for (int i = 0; i < 4; i++) begin haz(); step("wd_hold", 1, 0, 0, 8'd0); end
        haz(); step("wd_trip", 0, 0, 1, `TRAP_STALL);
        haz(); step("wd_after", 0, 0, 1, 8'd0);
        rst = 1; step("wd_rst", 0, 0, 0, 8'd0);
        step("wd_idle", 0, 0, 0, 8'd0);

        // reset mid-flush returns to RUN
        br_redirect = 1; step("rf_0", 0, 1, 0, 8'd0);
        rst = 1; step("rf_rst", 0, 0, 0, 8'd0);
        step("rf_1", 0, 0, 0, 8'd0);

`ifdef HAZARD_STATS_EN
        rst = 1; step("st_rst", 0, 0, 0, 8'd0);
        for (int i = 0; i < 2; i++) begin haz(); step("st_a", 1, 0, 0, 8'd0); end
        step("st_gap", 0, 0, 0, 8'd0);
        for (int i = 0; i < 2; i++) begin haz(); step("st_b", 1, 0, 0, 8'd0); end
        br_redirect = 1; step("st_br", 0, 1, 0, 8'd0);
        step("st_f1", 0, 1, 0, 8'd0);
        step("st_f2", 0, 1, 0, 8'd0);
        step("st_end", 0, 0, 0, 8'd0);
        @(negedge clk);
        chk("stall_cycles", stall_cycles, 32'd4);
        chk("flush_cycles", flush_cycles, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
